// File: rtl/carfield_pkg.sv
// Shared types and constants for the Carfield domain boot sequencer.
package carfield_pkg;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_WAIT_SECD,
    BOOT_SELECT,
    BOOT_HOLD,
    BOOT_SETTLE,
    BOOT_WAIT_ACK,
    BOOT_DONE,
    BOOT_ERROR
  } carfield_boot_state_e;

  localparam int unsigned BootIdxSafed = 0;
  localparam int unsigned BootIdxPulp  = 1;
  localparam int unsigned BootIdxSpatz = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/carfield_boot_cnt.sv
// Saturating up-counter shared by the hold, settle and timeout phases.
module carfield_boot_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic             hit
);

  localparam logic [Width:0] One = 1;

  logic [Width-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != '1)   cnt <= cnt + Width'(1);
  end

  // Fires on the edge that completes `limit` cycles since the last clear.
  assign hit = en && (({1'b0, cnt} + One) == {1'b0, limit});

endmodule

// File: rtl/carfield_domain_boot_seq.sv
// Sequential reset/fetch-enable release of Carfield domains after security island init.
module carfield_domain_boot_seq
  import carfield_pkg::*;
#(
  parameter int unsigned NumDomains    = 3,
  parameter int unsigned RstHoldCycles = 4,
  parameter int unsigned SettleCycles  = 2,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic                              secd_ready_i,
  input  logic [NumDomains-1:0]             domain_en_i,
  input  logic [NumDomains-1:0]             domain_ack_i,
  output logic [NumDomains-1:0]             domain_rst_no,
  output logic [NumDomains-1:0]             domain_fetch_en_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              error_o,
  output logic [$clog2(NumDomains+1)-1:0]   err_idx_o
);

  localparam int unsigned IdxW   = $clog2(NumDomains + 1);
  localparam int unsigned DomW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  localparam int unsigned CntMax = max3(RstHoldCycles, SettleCycles, TimeoutCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  carfield_boot_state_e  state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d, err_idx_q, err_idx_d;
  logic [DomW-1:0]       sel;
  logic [NumDomains-1:0] rst_q, rst_d, fetch_q, fetch_d;
  logic [CntW-1:0]       limit;
  logic                  hit, tmo, clr, busy;

  assign sel = idx_q[DomW-1:0];
  assign tmo = (TimeoutCycles != 0) && hit;
  assign clr = (state_d != state_q);

  always_comb begin
    case (state_q)
      BOOT_HOLD:   limit = CntW'(RstHoldCycles);
      BOOT_SETTLE: limit = CntW'(SettleCycles);
      default:     limit = CntW'(TimeoutCycles);
    endcase
  end

  carfield_boot_cnt #(.Width(CntW)) u_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clr),
    .en    (busy),
    .limit (limit),
    .hit   (hit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    fetch_d   = fetch_q;
    err_idx_d = err_idx_q;
    case (state_q)
      BOOT_IDLE, BOOT_DONE, BOOT_ERROR: begin
        if (start_i) begin
          state_d   = BOOT_WAIT_SECD;
          rst_d     = '0;
          fetch_d   = '0;
          idx_d     = '0;
          err_idx_d = '0;
        end
      end
      BOOT_WAIT_SECD: begin
        if (secd_ready_i) state_d = BOOT_SELECT;
        else if (tmo) begin
          state_d   = BOOT_ERROR;
          err_idx_d = IdxW'(NumDomains);
        end
      end
      BOOT_SELECT: begin
        if (idx_q == IdxW'(NumDomains)) state_d = BOOT_DONE;
        else if (!domain_en_i[sel])     idx_d   = idx_q + IdxW'(1);
        else                            state_d = BOOT_HOLD;
      end
      BOOT_HOLD: begin
        if (hit) begin
          rst_d[sel] = 1'b1;
          state_d    = BOOT_SETTLE;
        end
      end
      BOOT_SETTLE: begin
        if (hit) begin
          fetch_d[sel] = 1'b1;
          state_d      = BOOT_WAIT_ACK;
        end
      end
      BOOT_WAIT_ACK: begin
        // Ack is checked first so a coincident timeout still counts as success.
        if (domain_ack_i[sel]) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = BOOT_SELECT;
        end else if (tmo) begin
          rst_d[sel]   = 1'b0;
          fetch_d[sel] = 1'b0;
          err_idx_d    = idx_q;
          state_d      = BOOT_ERROR;
        end
      end
      default: state_d = BOOT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BOOT_IDLE;
      idx_q     <= '0;
      rst_q     <= '0;
      fetch_q   <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      fetch_q   <= fetch_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign busy = !(state_q inside {BOOT_IDLE, BOOT_DONE, BOOT_ERROR});

  assign domain_rst_no     = rst_q;
  assign domain_fetch_en_o = fetch_q;
  assign busy_o            = busy;
  assign done_o            = (state_q == BOOT_DONE);
  assign error_o           = (state_q == BOOT_ERROR);
  assign err_idx_o         = err_idx_q;

endmodule

// File: tb/tb_carfield_domain_boot_seq.sv
// Directed bench for the domain boot sequencer with a reset-release-order scoreboard.
module tb_carfield_domain_boot_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       secd_ready_i;
  logic [2:0] domain_en_i;
  logic [2:0] domain_ack_i;
  logic [2:0] domain_rst_no;
  logic [2:0] domain_fetch_en_o;
  logic       busy_o, done_o, error_o;
  logic [1:0] err_idx_o;

  int total = 0;
  int bad   = 0;
  int rel_q[$];
  logic [2:0] prev_rst;

  carfield_domain_boot_seq dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .start_i           (start_i),
    .secd_ready_i      (secd_ready_i),
    .domain_en_i       (domain_en_i),
    .domain_ack_i      (domain_ack_i),
    .domain_rst_no     (domain_rst_no),
    .domain_fetch_en_o (domain_fetch_en_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o),
    .err_idx_o         (err_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every reset release must match the next expected domain index.
  always @(negedge clk_i) begin
    if (!rst_ni) prev_rst <= domain_rst_no;
    else begin
      for (int i = 0; i < 3; i++) begin
        if (domain_rst_no[i] && !prev_rst[i]) begin
          if (rel_q.size() == 0) chk("release_unexpected", i, 32'hFF);
          else                   chk("release_order", i, rel_q.pop_front());
        end
      end
      prev_rst <= domain_rst_no;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic cond(input int kind, input int d);
    case (kind)
      0:       return domain_fetch_en_o[d];
      1:       return done_o;
      default: return error_o;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int kind, input int d, input int bound,
                          output int cyc);
    cyc = 0;
    while (!cond(kind, d) && cyc < bound) begin
      step(1);
      cyc++;
    end
    chk({tag, "_seen"}, {31'b0, cond(kind, d)}, 1);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  // Ack returned 3 cycles after the domain's fetch-enable rises.
  task automatic boot_domain(input int d);
    int c;
    wait_for("fetch", 0, d, 60, c);
    step(2);
    domain_ack_i[d] = 1'b1;
    step(1);
    domain_ack_i = '0;
  endtask

  initial begin
    int c;
    rst_ni = 1'b0; start_i = 1'b0; secd_ready_i = 1'b0;
    domain_en_i = 3'b111; domain_ack_i = '0;
    step(2);
    chk("rst_rst",     domain_rst_no, 0);
    chk("rst_fetch",   domain_fetch_en_o, 0);
    chk("rst_busy",    busy_o, 0);
    chk("rst_done",    done_o, 0);
    chk("rst_error",   error_o, 0);
    chk("rst_err_idx", err_idx_o, 0);
    rst_ni = 1'b1;
    step(1);

    // All domains enabled, secd ready up front.
    secd_ready_i = 1'b1;
    rel_q.push_back(0); rel_q.push_back(1); rel_q.push_back(2);
    pulse_start();
    chk("t1_busy", busy_o, 1);
    wait_for("t1_fetch0", 0, 0, 40, c);
    chk("t1_fetch0_cycle", c + 1, 9);
    step(2); domain_ack_i[0] = 1'b1; step(1); domain_ack_i = '0;
    boot_domain(1);
    boot_domain(2);
    wait_for("t1_done", 1, 0, 20, c);
    chk("t1_busy_end", busy_o, 0);
    chk("t1_rst_end",  domain_rst_no, 3'b111);
    chk("t1_fetch_end", domain_fetch_en_o, 3'b111);
    chk("t1_sb_empty", rel_q.size(), 0);

    // Domain 1 disabled: it must stay in reset.
    domain_en_i = 3'b101;
    rel_q.push_back(0); rel_q.push_back(2);
    pulse_start();
    boot_domain(0);
    boot_domain(2);
    wait_for("t2_done", 1, 0, 20, c);
    chk("t2_rst",   domain_rst_no, 3'b101);
    chk("t2_fetch", domain_fetch_en_o, 3'b101);
    chk("t2_sb_empty", rel_q.size(), 0);

    // Security island never ready: timeout 16 cycles after WAIT_SECD entry.
    secd_ready_i = 1'b0;
    domain_en_i  = 3'b111;
    pulse_start();
    wait_for("t3_error", 2, 0, 40, c);
    chk("t3_error_cycle", c + 1, 17);
    chk("t3_err_idx", err_idx_o, 3);
    chk("t3_rst",     domain_rst_no, 0);
    chk("t3_busy",    busy_o, 0);

    // Domain 1 never acks.
    secd_ready_i = 1'b1;
    rel_q.push_back(0); rel_q.push_back(1);
    pulse_start();
    chk("t4_err_cleared", error_o, 0);
    boot_domain(0);
    wait_for("t4_error", 2, 0, 60, c);
    chk("t4_err_idx", err_idx_o, 1);
    chk("t4_rst",     domain_rst_no, 3'b001);
    chk("t4_fetch",   domain_fetch_en_o, 3'b001);
    chk("t4_done",    done_o, 0);
    rel_q.push_back(0); rel_q.push_back(1); rel_q.push_back(2);
    pulse_start();
    chk("t4_restart_rst",   domain_rst_no, 0);
    chk("t4_restart_fetch", domain_fetch_en_o, 0);
    chk("t4_restart_err",   error_o, 0);
    chk("t4_restart_idx",   err_idx_o, 0);
    boot_domain(0);
    boot_domain(1);
    boot_domain(2);
    wait_for("t4_done", 1, 0, 20, c);
    chk("t4_sb_empty", rel_q.size(), 0);

    // Async reset during HOLD of domain 2.
    rel_q.push_back(0); rel_q.push_back(1);
    pulse_start();
    boot_domain(0);
    boot_domain(1);
    step(2);
    rst_ni = 1'b0;
    #2;
    chk("t5_rst",   domain_rst_no, 0);
    chk("t5_fetch", domain_fetch_en_o, 0);
    chk("t5_busy",  busy_o, 0);
    chk("t5_done",  done_o, 0);
    chk("t5_error", error_o, 0);
    rst_ni = 1'b1;
    step(8);
    chk("t5_idle_busy", busy_o, 0);
    chk("t5_idle_rst",  domain_rst_no, 0);
    chk("t5_sb_empty",  rel_q.size(), 0);

    // Ack on the same edge as the timeout wins.
    domain_en_i = 3'b001;
    rel_q.push_back(0);
    pulse_start();
    wait_for("t6_fetch0", 0, 0, 40, c);
    step(15);
    domain_ack_i[0] = 1'b1;
    step(1);
    domain_ack_i = '0;
    chk("t6_no_error", error_o, 0);
    wait_for("t6_done", 1, 0, 20, c);
    chk("t6_error_end", error_o, 0);
    chk("t6_fetch", domain_fetch_en_o, 3'b001);
    chk("t6_sb_empty", rel_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
